// File: rtl/nibble_add_sequencer.sv
// rtl/nibble_add_sequencer.sv - multi-digit adder sharing one 4-bit CLA, LS nibble first
//
// nibble_add_sequencer: adds two DIGITS-nibble operands one nibble per clock
// through a single CLA4bit, with optional per-digit BCD correction.
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   start           request, sampled only while idle
//   A, B, CI        operands and carry-in, captured when start is accepted
//   busy            high from the cycle after acceptance through the done cycle
//   done            one-cycle pulse; SUM/CO/err valid from this cycle
//   SUM, CO, err    registered result, held until the next done
// CLA4bit: 4-bit carry-lookahead adder (A, B, CI -> SUM, CO).

module CLA4bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       CI,
  output logic [3:0] SUM,
  output logic       CO
);
  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p = A ^ B;
  assign g = A & B;

  // Each carry is expanded in terms of generate/propagate and CI only.
  assign c[0] = CI;
  assign c[1] = g[0] | (p[0] & CI);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & CI);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & CI);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & CI);

  assign SUM = p ^ c[3:0];
  assign CO  = c[4];
endmodule

module nibble_add_sequencer #(
  parameter int DIGITS = 4,
  parameter bit BCD    = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] A,
  input  logic [4*DIGITS-1:0] B,
  input  logic                CI,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] SUM,
  output logic                CO,
  output logic                err
);
  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_next;

  logic [IW-1:0] idx;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [W-1:0]  acc;
  logic [W-1:0]  acc_next;
  logic          carry;
  logic          carry_next;
  logic          err_flag;

  logic [3:0]    a_nib;
  logic [3:0]    b_nib;
  logic [3:0]    cla_sum;
  logic          cla_co;
  logic [3:0]    digit;
  logic          nib_bad;
  logic          last;

  assign a_nib = a_reg[{idx, 2'b00} +: 4];
  assign b_nib = b_reg[{idx, 2'b00} +: 4];
  assign last  = (idx == IW'(DIGITS - 1));

  CLA4bit u_cla (
    .A   (a_nib),
    .B   (b_nib),
    .CI  (carry),
    .SUM (cla_sum),
    .CO  (cla_co)
  );

  if (BCD) begin : g_bcd
    logic [4:0] raw;
    assign raw = {cla_co, cla_sum};
    // Decimal correction: any raw nibble sum above 9 skips the six unused codes.
    always_comb begin
      digit      = cla_sum;
      carry_next = 1'b0;
      if (raw > 5'd9) begin
        digit      = cla_sum + 4'd6;
        carry_next = 1'b1;
      end
    end
    assign nib_bad = (a_nib > 4'd9) || (b_nib > 4'd9);
  end else begin : g_bin
    assign digit      = cla_sum;
    assign carry_next = cla_co;
    assign nib_bad    = 1'b0;
  end

  // Accumulator with the current digit merged in, so the DONE-entry edge can
  // publish the complete result in the same cycle the last digit lands.
  always_comb begin
    acc_next                      = acc;
    acc_next[{idx, 2'b00} +: 4]   = digit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (last) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      acc      <= '0;
      carry    <= 1'b0;
      err_flag <= 1'b0;
      SUM      <= '0;
      CO       <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_reg    <= A;
            b_reg    <= B;
            carry    <= CI;
            idx      <= '0;
            acc      <= '0;
            err_flag <= 1'b0;
          end
        end
        S_RUN: begin
          acc      <= acc_next;
          carry    <= carry_next;
          err_flag <= err_flag | nib_bad;
          if (last) begin
            SUM <= acc_next;
            CO  <= carry_next;
            err <= err_flag | nib_bad;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end
endmodule
